id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS pipeline. It sits directly downstream of the opcode control decoder. Each cycle it captures the decoder's control signals with the ID-stage operands, or inserts a bubble. It drives stall and flush requests back to the PC/IF-ID logic and keeps a saturating count of inserted load-use bubbles.

## Interface
- No parameters; datapath fixed at 32 bits, register specifiers at 5 bits.
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- hold_i  in  1  global freeze (memory wait); register and counter hold
- branch_taken_i  in  1  branch resolved taken in EX; ID instruction is wrong-path
- id_valid  in  1  IF/ID holds a real instruction
- regdst, jump, branch_beq, branch_bne, memread, memtoreg, memwrite, regwrite, alusrc  in  1 each  decoder control outputs for the ID instruction
- aluop  in  2  decoder ALU op class
- id_pc4, id_rd1, id_rd2, id_imm  in  32 each  PC+4, register-file reads, sign-extended immediate
- id_rs, id_rt, id_rd  in  5 each  register specifiers; id_funct  in  6
- ex_valid  out  1  EX register holds a real instruction
- ex_regdst … ex_alusrc  out  1 each  registered copies of the nine 1-bit controls (ex_jump included)
- ex_aluop  out  2;  ex_pc4, ex_rd1, ex_rd2, ex_imm  out  32;  ex_rs, ex_rt, ex_rd  out  5;  ex_funct  out  6
- stall_o  out  1  combinational: PC and IF/ID must hold this cycle
- if_flush_o  out  1  combinational: IF/ID must load a bubble this cycle
- stall_cnt  out  16  saturating count of load-use bubbles inserted

## Operation
- uses_rt = regdst | branch_beq | branch_bne | memwrite. R-type, beq, bne and sw read rt; lw, addi, andi and j do not.
- load_use = ex_valid & ex_memread & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (uses_rt & ex_rt == id_rt)).
- stall_o = ~hold_i & ~branch_taken_i & load_use.
- if_flush_o = ~hold_i & (branch_taken_i | (id_valid & jump & ~load_use)).
- Register update priority at each rising edge, highest first:
  1. hold_i=1: every ex_* output and stall_cnt keep their value.
  2. branch_taken_i=1: bubble.
  3. load_use=1: bubble; stall_cnt increments unless it is 16'hFFFF.
  4. Otherwise: load. ex_valid<=id_valid; every control output takes its input AND id_valid; data and specifier fields take the ID values.
- Bubble means ex_valid<=0, all nine 1-bit controls <=0 and ex_aluop<=2'b00. Data and specifier fields still capture the ID values; these are don't-care downstream but are defined for the bench.
- j passes through normally with ex_jump=1, and the same cycle asserts if_flush_o. A jump held by load_use does not flush until the cycle it is accepted.
- stall_cnt changes only on reset and on a load-use bubble; it saturates at 16'hFFFF and never wraps.

## Timing
- Reset (rst_n low, asynchronous): ex_valid=0, all controls 0, ex_aluop=00, all data/specifier outputs 0, stall_cnt=0. stall_o and if_flush_o follow their equations, evaluated with the zeroed register.
- Reset deasserting mid-stream: the first edge after release performs a normal priority evaluation, with no spurious bubble counted.
- Latency: 1 cycle from ID inputs to ex_* outputs.
- stall_o and if_flush_o are valid in the same cycle as their inputs, with no registered delay. Upstream samples them at the same edge this block updates.
- A load-use stall lasts exactly one cycle: the bubble clears ex_memread, so load_use drops the next cycle while the held ID instruction is re-presented.
- hold_i and a hazard in the same cycle: hold wins. Nothing changes, stall_o=0, and the hazard is re-evaluated after the hold releases.
- branch_taken_i and load_use in the same cycle: flush wins, stall_o=0, and stall_cnt is unchanged.

## Test plan
- Reset: drive arbitrary inputs and pulse rst_n low between edges. All outputs read 0 immediately, with no clock edge; stall_cnt=0.
- lw pass-through: id_valid=1 with lw controls (memread=memtoreg=regwrite=alusrc=1, aluop=00) and id_rt=5. After one edge ex_valid=1 with matching controls, ex_rt=5, and stall_o=0.
- Load-use: EX holds lw rt=5 and ID holds add rs=3 rt=5 (regdst=1). Response: stall_o=1, if_flush_o=0; next edge ex_valid=0 with all controls 0 and stall_cnt=1. On the following cycle stall_o=0, and the add enters EX on the next edge.
- Hazard filters, with EX holding lw rt=5:
  - ID addi with id_rt=5 gives stall_o=0.
  - ID sw with id_rt=5 gives stall_o=1.
  - EX lw with rt=0 and ID rs=0 gives stall_o=0.
- Priorities: load_use with branch_taken_i=1 gives stall_o=0, if_flush_o=1, a bubble, and stall_cnt unchanged. Adding hold_i=1 gives both outputs 0 and all ex_* frozen over 3 cycles.
- Jump and saturation: ID j with id_valid=1 gives if_flush_o=1 and ex_jump=1 after the edge. Force 65536 load-use bubbles and check stall_cnt stays at 16'hFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// branch/jump flush requests and a saturating load-use bubble counter.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold_i,
    input  logic        branch_taken_i,
    input  logic        id_valid,
    input  logic        regdst,
    input  logic        jump,
    input  logic        branch_beq,
    input  logic        branch_bne,
    input  logic        memread,
    input  logic        memtoreg,
    input  logic        memwrite,
    input  logic        regwrite,
    input  logic        alusrc,
    input  logic [1:0]  aluop,
    input  logic [31:0] id_pc4,
    input  logic [31:0] id_rd1,
    input  logic [31:0] id_rd2,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [5:0]  id_funct,
    output logic        ex_valid,
    output logic        ex_regdst,
    output logic        ex_jump,
    output logic        ex_branch_beq,
    output logic        ex_branch_bne,
    output logic        ex_memread,
    output logic        ex_memtoreg,
    output logic        ex_memwrite,
    output logic        ex_regwrite,
    output logic        ex_alusrc,
    output logic [1:0]  ex_aluop,
    output logic [31:0] ex_pc4,
    output logic [31:0] ex_rd1,
    output logic [31:0] ex_rd2,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_rd,
    output logic [5:0]  ex_funct,
    output logic        stall_o,
    output logic        if_flush_o,
    output logic [15:0] stall_cnt
);

    typedef struct packed {
        logic        valid;
        logic [8:0]  ctrl;   // regdst,jump,beq,bne,memread,memtoreg,memwrite,regwrite,alusrc
        logic [1:0]  aluop;
        logic [31:0] pc4;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
    } ex_reg_t;

    ex_reg_t     ex_q;
    ex_reg_t     ex_d;
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;
    logic        uses_rt_s;
    logic        load_use_s;
    logic [8:0]  id_ctrl_s;

    assign id_ctrl_s = {regdst, jump, branch_beq, branch_bne, memread,
                        memtoreg, memwrite, regwrite, alusrc};

    // Hazard detection and upstream stall/flush requests
    always_comb begin
        uses_rt_s  = regdst | branch_beq | branch_bne | memwrite;
        load_use_s = ex_q.valid & ex_q.ctrl[4] & (ex_q.rt != 5'd0) & id_valid &
                     ((ex_q.rt == id_rs) | (uses_rt_s & (ex_q.rt == id_rt)));
        stall_o    = ~hold_i & ~branch_taken_i & load_use_s;
        if_flush_o = ~hold_i & (branch_taken_i | (id_valid & jump & ~load_use_s));
    end

    // Next-state selection: hold, then flush/load-use bubble, then normal load
    always_comb begin
        ex_d        = ex_q;
        stall_cnt_d = stall_cnt_q;
        if (hold_i) begin
            ex_d        = ex_q;
            stall_cnt_d = stall_cnt_q;
        end else begin
            ex_d.pc4   = id_pc4;
            ex_d.rd1   = id_rd1;
            ex_d.rd2   = id_rd2;
            ex_d.imm   = id_imm;
            ex_d.rs    = id_rs;
            ex_d.rt    = id_rt;
            ex_d.rd    = id_rd;
            ex_d.funct = id_funct;
            if (branch_taken_i || load_use_s) begin
                ex_d.valid = 1'b0;
                ex_d.ctrl  = 9'd0;
                ex_d.aluop = 2'b00;
            end else begin
                ex_d.valid = id_valid;
                ex_d.ctrl  = id_ctrl_s & {9{id_valid}};
                ex_d.aluop = aluop & {2{id_valid}};
            end
            // Only bubbles caused by load-use are counted, never flushes
            if (!branch_taken_i && load_use_s && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
        end
    end

    // EX-stage register and bubble counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            stall_cnt_q <= 16'd0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_regdst     = ex_q.ctrl[8];
    assign ex_jump       = ex_q.ctrl[7];
    assign ex_branch_beq = ex_q.ctrl[6];
    assign ex_branch_bne = ex_q.ctrl[5];
    assign ex_memread    = ex_q.ctrl[4];
    assign ex_memtoreg   = ex_q.ctrl[3];
    assign ex_memwrite   = ex_q.ctrl[2];
    assign ex_regwrite   = ex_q.ctrl[1];
    assign ex_alusrc     = ex_q.ctrl[0];
    assign ex_aluop      = ex_q.aluop;
    assign ex_pc4        = ex_q.pc4;
    assign ex_rd1        = ex_q.rd1;
    assign ex_rd2        = ex_q.rd2;
    assign ex_imm        = ex_q.imm;
    assign ex_rs         = ex_q.rs;
    assign ex_rt         = ex_q.rt;
    assign ex_rd         = ex_q.rd;
    assign ex_funct      = ex_q.funct;
    assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, reset and
// saturation sequences, then randomized traffic against a reference model.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [8:0]  ctrl;
        logic [1:0]  aluop;
        logic [31:0] pc4;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
    } ins_t;

    typedef struct {
        ins_t id;
        bit   hold;
        bit   bt;
        bit   e_stall;
        bit   e_flush;
        bit   e_valid;
        bit   e_jump;
        int   e_cnt;
    } vec_t;

    localparam logic [8:0] C_LW   = 9'b0_0001_1011;
    localparam logic [8:0] C_ADD  = 9'b1_0000_0010;
    localparam logic [8:0] C_ADDI = 9'b0_0000_0011;
    localparam logic [8:0] C_SW   = 9'b0_0000_0101;
    localparam logic [8:0] C_J    = 9'b0_1000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hold = 1'b0;
    logic bt = 1'b0;
    ins_t id = '0;

    logic        ex_valid, ex_regdst, ex_jump, ex_beq, ex_bne, ex_memread;
    logic        ex_memtoreg, ex_memwrite, ex_regwrite, ex_alusrc;
    logic [1:0]  ex_aluop;
    logic [31:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [5:0]  ex_funct;
    logic        stall_o, if_flush_o;
    logic [15:0] stall_cnt;
    ins_t        ex_got;

    int errors = 0;
    int checks = 0;
    ins_t m_ex = '0;
    int unsigned m_cnt = 0;
    vec_t tbl[21];

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .hold_i(hold), .branch_taken_i(bt),
        .id_valid(id.valid),
        .regdst(id.ctrl[8]), .jump(id.ctrl[7]), .branch_beq(id.ctrl[6]),
        .branch_bne(id.ctrl[5]), .memread(id.ctrl[4]), .memtoreg(id.ctrl[3]),
        .memwrite(id.ctrl[2]), .regwrite(id.ctrl[1]), .alusrc(id.ctrl[0]),
        .aluop(id.aluop), .id_pc4(id.pc4), .id_rd1(id.rd1), .id_rd2(id.rd2),
        .id_imm(id.imm), .id_rs(id.rs), .id_rt(id.rt), .id_rd(id.rd),
        .id_funct(id.funct),
        .ex_valid(ex_valid), .ex_regdst(ex_regdst), .ex_jump(ex_jump),
        .ex_branch_beq(ex_beq), .ex_branch_bne(ex_bne), .ex_memread(ex_memread),
        .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite),
        .ex_regwrite(ex_regwrite), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
        .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct),
        .stall_o(stall_o), .if_flush_o(if_flush_o), .stall_cnt(stall_cnt)
    );

    assign ex_got = {ex_valid, ex_regdst, ex_jump, ex_beq, ex_bne, ex_memread,
                     ex_memtoreg, ex_memwrite, ex_regwrite, ex_alusrc, ex_aluop,
                     ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_funct};

    function automatic ins_t mk(input logic [8:0] c, input logic [1:0] a,
                                input logic [4:0] rs, input logic [4:0] rt);
        ins_t r;
        r.valid = 1'b1;
        r.ctrl  = c;
        r.aluop = a;
        r.pc4   = $urandom;
        r.rd1   = $urandom;
        r.rd2   = $urandom;
        r.imm   = $urandom;
        r.rs    = rs;
        r.rt    = rt;
        r.rd    = 5'($urandom);
        r.funct = 6'($urandom);
        return r;
    endfunction

    // Reference hazard rule: a load in EX whose destination is read by ID
    function automatic bit m_lu(input ins_t e, input ins_t d);
        bit reads_rt;
        reads_rt = d.ctrl[8] | d.ctrl[6] | d.ctrl[5] | d.ctrl[2];
        return e.valid && e.ctrl[4] && (e.rt != 5'd0) && d.valid &&
               ((e.rt == d.rs) || (reads_rt && (e.rt == d.rt)));
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_ex(input string name, input ins_t exp);
        checks++;
        if (ex_got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, ex_got, exp);
        end
    endtask

    task automatic comb_phase();
        bit lu;
        lu = m_lu(m_ex, id);
        #1;
        chk("stall_o", 32'(stall_o), 32'(!hold && !bt && lu));
        chk("if_flush_o", 32'(if_flush_o), 32'(!hold && (bt || (id.valid && id.ctrl[7] && !lu))));
    endtask

    task automatic edge_phase();
        bit lu;
        lu = m_lu(m_ex, id);
        @(posedge clk);
        if (!hold) begin
            if (bt || lu) begin
                m_ex = id;
                m_ex.valid = 1'b0;
                m_ex.ctrl  = '0;
                m_ex.aluop = '0;
                if (!bt && m_cnt < 65535) m_cnt++;
            end else begin
                m_ex = id;
                if (!id.valid) begin
                    m_ex.ctrl  = '0;
                    m_ex.aluop = '0;
                end
            end
        end
        #1;
        chk_ex("ex_state", m_ex);
        chk("stall_cnt", 32'(stall_cnt), m_cnt);
        @(negedge clk);
    endtask

    task automatic cycle();
        comb_phase();
        edge_phase();
    endtask

    initial begin
        // Directed sequence: load-use, filters, priorities, jump, invalid ID
        tbl[0]  = '{mk(C_LW,   2'b00, 5'd1, 5'd5), 0, 0, 0, 0, 1, 0, 0};
        tbl[1]  = '{mk(C_ADD,  2'b10, 5'd3, 5'd5), 0, 0, 1, 0, 0, 0, 1};
        tbl[2]  = '{tbl[1].id,                     0, 0, 0, 0, 1, 0, 1};
        tbl[3]  = '{mk(C_LW,   2'b00, 5'd1, 5'd5), 0, 0, 0, 0, 1, 0, 1};
        tbl[4]  = '{mk(C_ADDI, 2'b00, 5'd2, 5'd5), 0, 0, 0, 0, 1, 0, 1};
        tbl[5]  = '{mk(C_LW,   2'b00, 5'd1, 5'd5), 0, 0, 0, 0, 1, 0, 1};
        tbl[6]  = '{mk(C_SW,   2'b00, 5'd2, 5'd5), 0, 0, 1, 0, 0, 0, 2};
        tbl[7]  = '{mk(C_LW,   2'b00, 5'd0, 5'd0), 0, 0, 0, 0, 1, 0, 2};
        tbl[8]  = '{mk(C_ADD,  2'b10, 5'd0, 5'd0), 0, 0, 0, 0, 1, 0, 2};
        tbl[9]  = '{mk(C_LW,   2'b00, 5'd1, 5'd5), 0, 0, 0, 0, 1, 0, 2};
        tbl[10] = '{mk(C_ADD,  2'b10, 5'd5, 5'd2), 0, 1, 0, 1, 0, 0, 2};
        tbl[11] = '{mk(C_LW,   2'b00, 5'd1, 5'd5), 0, 0, 0, 0, 1, 0, 2};
        tbl[12] = '{mk(C_ADD,  2'b10, 5'd5, 5'd2), 1, 0, 0, 0, 1, 0, 2};
        tbl[13] = '{tbl[12].id,                    1, 1, 0, 0, 1, 0, 2};
        tbl[14] = '{tbl[12].id,                    1, 0, 0, 0, 1, 0, 2};
        tbl[15] = '{tbl[12].id,                    0, 0, 1, 0, 0, 0, 3};
        tbl[16] = '{mk(C_J,    2'b00, 5'd9, 5'd9), 0, 0, 0, 1, 1, 1, 3};
        tbl[17] = '{mk(C_LW,   2'b00, 5'd1, 5'd7), 0, 0, 0, 0, 1, 0, 3};
        tbl[18] = '{mk(C_J,    2'b00, 5'd7, 5'd0), 0, 0, 1, 0, 0, 0, 4};
        tbl[19] = '{tbl[18].id,                    0, 0, 0, 1, 1, 1, 4};
        tbl[20] = '{mk(C_LW,   2'b00, 5'd1, 5'd5), 0, 0, 0, 0, 0, 0, 4};
        tbl[20].id.valid = 1'b0;

        // Reset with arbitrary inputs: outputs zero before any clock edge
        id = mk(9'($urandom), 2'($urandom), 5'($urandom), 5'($urandom));
        #2;
        chk_ex("reset_ex", '0);
        chk("reset_cnt", 32'(stall_cnt), 32'd0);
        chk("reset_stall", 32'(stall_o), 32'd0);
        chk("reset_flush", 32'(if_flush_o), 32'(id.ctrl[7]));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            id   = tbl[i].id;
            hold = tbl[i].hold;
            bt   = tbl[i].bt;
            comb_phase();
            chk($sformatf("vec%0d_stall", i), 32'(stall_o), 32'(tbl[i].e_stall));
            chk($sformatf("vec%0d_flush", i), 32'(if_flush_o), 32'(tbl[i].e_flush));
            edge_phase();
            chk($sformatf("vec%0d_valid", i), 32'(ex_valid), 32'(tbl[i].e_valid));
            chk($sformatf("vec%0d_jump", i), 32'(ex_jump), 32'(tbl[i].e_jump));
            chk($sformatf("vec%0d_cnt", i), 32'(stall_cnt), tbl[i].e_cnt);
        end
        hold = 1'b0;
        bt   = 1'b0;

        // Reset mid-stream while a hazard is pending: no bubble counted after release
        id = mk(C_LW, 2'b00, 5'd1, 5'd5);
        cycle();
        id = mk(C_ADD, 2'b10, 5'd5, 5'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_ex("midreset_ex", '0);
        chk("midreset_cnt", 32'(stall_cnt), 32'd0);
        #1;
        rst_n = 1'b1;
        m_ex  = '0;
        m_cnt = 0;
        cycle();
        chk("midreset_add_valid", 32'(ex_valid), 32'd1);
        chk("midreset_nobubble", 32'(stall_cnt), 32'd0);

        // Saturation: preload the counter near the top, then keep forcing bubbles
        force dut.stall_cnt_q = 16'hFFFA;
        #1;
        release dut.stall_cnt_q;
        m_cnt = 32'h0000FFFA;
        for (int k = 0; k < 9; k++) begin
            id = mk(C_LW, 2'b00, 5'd1, 5'd5);
            cycle();
            id = mk(C_LW, 2'b00, 5'd5, 5'd6);
            cycle();
            cycle();
        end
        chk("saturated", 32'(stall_cnt), 32'h0000FFFF);

        // Randomized traffic with small register numbers to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            id = mk(9'($urandom), 2'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 0) id.ctrl[4] = 1'b1;
            id.valid = ($urandom_range(0, 4) != 0);
            hold = ($urandom_range(0, 7) == 0);
            bt   = ($urandom_range(0, 7) == 0);
            if (n == 100) begin
                m_cnt = 0;
                rst_n = 1'b0;
                m_ex  = '0;
                #1;
                rst_n = 1'b1;
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
